// File: rtl/circ_buffer_if.sv
// Producer/consumer port bundle for circ_buffer: write group in, read window out, flags back.
interface circ_buffer_if #(
  parameter int SIZE      = 4,
  parameter int MEM_SIZE  = 4,
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 4,
  parameter int CNT_W     = $clog2(MEM_SIZE + 1)
);
  logic                      clr;
  logic                      wen;
  logic [PAR_WRITE*SIZE-1:0] din;
  logic                      full;
  logic                      ren;
  logic [PAR_READ*SIZE-1:0]  dout;
  logic                      rvalid;
  logic                      empty;
  logic [CNT_W-1:0]          count;
  logic                      ovf;
  logic                      udf;

  modport master (
    output clr, wen, din, ren,
    input  full, dout, rvalid, empty, count, ovf, udf
  );

  modport slave (
    input  clr, wen, din, ren,
    output full, dout, rvalid, empty, count, ovf, udf
  );
endinterface

// File: rtl/circ_buffer.sv
// Circular buffer taking PAR_WRITE elements per write and presenting PAR_READ-element windows.
// Read window is combinational from state (1-cycle write-to-read); full/rvalid gate acceptance.
module circ_buffer #(
  parameter int SIZE      = 4,
  parameter int MEM_SIZE  = 4,
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 4,
  parameter int CNT_W     = $clog2(MEM_SIZE + 1)
) (
  input logic          clk,
  input logic          rst,
  circ_buffer_if.slave bus
);
  localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [SIZE-1:0]          mem [MEM_SIZE];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            rptr;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf_q;
  logic                     udf_q;
  logic                     full;
  logic                     rvalid;
  logic                     flush;
  logic                     wr_acc;
  logic                     rd_acc;
  logic [PAR_READ*SIZE-1:0] win;

  // Depth need not be a power of two, so wrap by compare-and-subtract.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int k);
    logic [AW+1:0] s;
    s = {2'b00, p} + (AW+2)'(k);
    if (s >= (AW+2)'(MEM_SIZE))
      s = s - (AW+2)'(MEM_SIZE);
    return s[AW-1:0];
  endfunction

  assign full   = (CNT_W'(MEM_SIZE) - cnt) < CNT_W'(PAR_WRITE);
  assign rvalid = cnt >= CNT_W'(PAR_READ);
  assign flush  = rst | bus.clr;
  assign wr_acc = bus.wen & ~full & ~flush;
  assign rd_acc = bus.ren & rvalid & ~flush;

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_acc)
        wptr <= wrap_add(wptr, PAR_WRITE);
      if (rd_acc)
        rptr <= wrap_add(rptr, PAR_READ);
      cnt <= cnt + (wr_acc ? CNT_W'(PAR_WRITE) : '0) - (rd_acc ? CNT_W'(PAR_READ) : '0);
      if (bus.wen & full)
        ovf_q <= 1'b1;
      if (bus.ren & ~rvalid)
        udf_q <= 1'b1;
    end
  end

  // Storage is not flushed; stale contents stay hidden behind the rvalid gate.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < PAR_WRITE; i++)
        mem[wrap_add(wptr, i)] <= bus.din[i*SIZE +: SIZE];
    end
  end

  always_comb begin
    win = '0;
    if (rvalid) begin
      for (int j = 0; j < PAR_READ; j++)
        win[j*SIZE +: SIZE] = mem[wrap_add(rptr, j)];
    end
  end

  assign bus.dout   = win;
  assign bus.full   = full;
  assign bus.rvalid = rvalid;
  assign bus.empty  = (cnt == '0);
  assign bus.count  = cnt;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;
endmodule

// File: tb/tb_circ_buffer.sv
// Directed and randomized checks of circ_buffer in three geometries against a queue model.
module tb_circ_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // geometry A: 4/4/2/4, B: 4/6/2/3, C: 8/8/2/2
  circ_buffer_if #(.SIZE(4), .MEM_SIZE(4), .PAR_WRITE(2), .PAR_READ(4)) ia();
  circ_buffer_if #(.SIZE(4), .MEM_SIZE(6), .PAR_WRITE(2), .PAR_READ(3)) ib();
  circ_buffer_if #(.SIZE(8), .MEM_SIZE(8), .PAR_WRITE(2), .PAR_READ(2)) ic();

  circ_buffer #(.SIZE(4), .MEM_SIZE(4), .PAR_WRITE(2), .PAR_READ(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  circ_buffer #(.SIZE(4), .MEM_SIZE(6), .PAR_WRITE(2), .PAR_READ(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  circ_buffer #(.SIZE(8), .MEM_SIZE(8), .PAR_WRITE(2), .PAR_READ(2)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  // Reference model for B: element queue in arrival order plus sticky flags.
  logic [3:0] mq[$];
  bit         movf;
  bit         mudf;

  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    movf = 1'b0;
    mudf = 1'b0;
  endtask

  task automatic check_b(input string tag);
    logic [11:0] w;
    w = '0;
    if (mq.size() >= 3)
      for (int j = 0; j < 3; j++) w[j*4 +: 4] = mq[j];
    chk({tag, "_dout"},   64'(ib.dout),   64'(w));
    chk({tag, "_count"},  64'(ib.count),  64'(mq.size()));
    chk({tag, "_full"},   64'(ib.full),   64'((6 - mq.size()) < 2));
    chk({tag, "_rvalid"}, 64'(ib.rvalid), 64'(mq.size() >= 3));
    chk({tag, "_empty"},  64'(ib.empty),  64'(mq.size() == 0));
    chk({tag, "_ovf"},    64'(ib.ovf),    64'(movf));
    chk({tag, "_udf"},    64'(ib.udf),    64'(mudf));
  endtask

  task automatic step_b(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
    bit mfull;
    bit mrv;
    ib.wen = w; ib.din = d; ib.ren = r; ib.clr = c;
    tick();
    ib.wen = 1'b0; ib.ren = 1'b0; ib.clr = 1'b0;
    if (c) begin
      mq.delete();
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      mfull = (6 - mq.size()) < 2;
      mrv   = mq.size() >= 3;
      if (w && mfull) movf = 1'b1;
      if (r && !mrv)  mudf = 1'b1;
      if (r && mrv)   repeat (3) void'(mq.pop_front());
      if (w && !mfull) begin
        mq.push_back(d[3:0]);
        mq.push_back(d[7:4]);
      end
    end
    check_b(tag);
  endtask

  initial begin
    rst = 1'b1;
    ia.wen = 0; ia.ren = 0; ia.clr = 0; ia.din = '0;
    ib.wen = 0; ib.ren = 0; ib.clr = 0; ib.din = '0;
    ic.wen = 0; ic.ren = 0; ic.clr = 0; ic.din = '0;
    tick();
    do_reset();

    chk("a_rst_count",  64'(ia.count),  64'd0);
    chk("a_rst_full",   64'(ia.full),   64'd0);
    chk("a_rst_rvalid", 64'(ia.rvalid), 64'd0);
    chk("a_rst_empty",  64'(ia.empty),  64'd1);
    chk("a_rst_dout",   64'(ia.dout),   64'd0);
    chk("a_rst_ovf",    64'(ia.ovf),    64'd0);
    chk("a_rst_udf",    64'(ia.udf),    64'd0);
    check_b("b_rst");

    ia.wen = 1; ia.din = 8'h21; tick(); ia.wen = 0;
    chk("a_w1_count",  64'(ia.count),  64'd2);
    chk("a_w1_rvalid", 64'(ia.rvalid), 64'd0);
    chk("a_w1_dout",   64'(ia.dout),   64'd0);
    ia.wen = 1; ia.din = 8'h43; tick(); ia.wen = 0;
    chk("a_w2_count",  64'(ia.count),  64'd4);
    chk("a_w2_full",   64'(ia.full),   64'd1);
    chk("a_w2_rvalid", 64'(ia.rvalid), 64'd1);
    chk("a_w2_dout",   64'(ia.dout),   64'h4321);
    ia.wen = 1; ia.din = 8'h99; tick(); ia.wen = 0;
    chk("a_ovf_set",   64'(ia.ovf),    64'd1);
    chk("a_ovf_dout",  64'(ia.dout),   64'h4321);
    chk("a_ovf_count", 64'(ia.count),  64'd4);
    tick();
    chk("a_ovf_sticky", 64'(ia.ovf),   64'd1);
    ia.ren = 1; tick(); ia.ren = 0;
    chk("a_rd_count",  64'(ia.count),  64'd0);
    chk("a_rd_empty",  64'(ia.empty),  64'd1);
    chk("a_rd_dout",   64'(ia.dout),   64'd0);
    ia.ren = 1; tick(); ia.ren = 0;
    chk("a_udf_set",   64'(ia.udf),    64'd1);
    chk("a_udf_count", 64'(ia.count),  64'd0);
    do_reset();
    chk("a_clr_ovf",   64'(ia.ovf),    64'd0);
    chk("a_clr_udf",   64'(ia.udf),    64'd0);

    // Non-power-of-two wrap
    step_b("b_w1", 1, 8'h21, 0, 0);
    step_b("b_w2", 1, 8'h43, 0, 0);
    step_b("b_w3", 1, 8'h65, 0, 0);
    chk("b_win1", 64'(ib.dout), 64'h321);
    step_b("b_r1", 0, 8'h00, 1, 0);
    step_b("b_w4", 1, 8'h87, 0, 0);
    chk("b_win2", 64'(ib.dout), 64'h654);
    step_b("b_r2", 0, 8'h00, 1, 0);
    step_b("b_r3", 0, 8'h00, 1, 0);
    chk("b_wrap_count", 64'(ib.count), 64'd2);

    // Simultaneous write and read
    do_reset();
    step_b("b_s1", 1, 8'h21, 0, 0);
    step_b("b_s2", 1, 8'h43, 0, 0);
    step_b("b_s3", 1, 8'h65, 0, 0);
    step_b("b_s4", 0, 8'h00, 1, 0);
    chk("b_sim_old_win", 64'(ib.dout), 64'h654);
    step_b("b_sim1", 1, 8'hA9, 1, 0);
    chk("b_sim1_count", 64'(ib.count), 64'd2);
    step_b("b_sim2", 1, 8'hCB, 1, 0);
    chk("b_sim2_count", 64'(ib.count), 64'd4);
    chk("b_sim2_udf",   64'(ib.udf),   64'd1);

    // Flush with a concurrent write
    step_b("b_clr", 1, 8'hED, 0, 1);
    chk("b_clr_count", 64'(ib.count), 64'd0);
    chk("b_clr_empty", 64'(ib.empty), 64'd1);
    chk("b_clr_dout",  64'(ib.dout),  64'd0);
    step_b("b_pc1", 1, 8'h21, 0, 0);
    step_b("b_pc2", 1, 8'h43, 0, 0);
    chk("b_pc_win", 64'(ib.dout), 64'h321);

    for (int i = 0; i < 400; i++)
      step_b("b_rnd", 1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);

    // Streaming on C
    do_reset();
    sb.delete();
    ic.wen = 1; ic.din = {8'd1, 8'd0};
    sb.push_back(8'd0); sb.push_back(8'd1);
    tick();
    ic.ren = 1;
    for (int k = 1; k <= 100; k++) begin
      ic.din = {8'(2*k + 1), 8'(2*k)};
      chk("c_full",   64'(ic.full),   64'd0);
      chk("c_rvalid", 64'(ic.rvalid), 64'd1);
      chk("c_dout",   64'(ic.dout),   64'({sb[1], sb[0]}));
      void'(sb.pop_front());
      void'(sb.pop_front());
      sb.push_back(8'(2*k));
      sb.push_back(8'(2*k + 1));
      tick();
    end
    ic.wen = 0; ic.ren = 0;
    chk("c_ovf",   64'(ic.ovf),   64'd0);
    chk("c_udf",   64'(ic.udf),   64'd0);
    chk("c_count", 64'(ic.count), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
